mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2:1 mux output channel between requesters A and B.
//  Each requester sends bursts of WIDTH-bit beats (valid/ready/last). The arbiter grants
//  one requester, drives the mux select and routes the handshake until the burst ends
//  or a beat limit forces a handover. It sits in front of any single-consumer datapath.
// PARAMETERS
//  WIDTH      8   data beat width in bits
//  MAX_BEATS  4   max beats per grant before forced handover (>=1); counter is $clog2(MAX_BEATS)+1 bits
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  a_valid    in   1      A has a beat on a_data
//  a_data     in   WIDTH  A beat
//  a_last     in   1      A beat is the last of its burst
//  a_ready    out  1      A beat accepted this cycle when a_valid & a_ready
//  b_valid    in   1      B has a beat on b_data
//  b_data     in   WIDTH  B beat
//  b_last     in   1      B beat is the last of its burst
//  b_ready    out  1      B beat accepted this cycle when b_valid & b_ready
//  out_valid  out  1      shared channel beat valid
//  out_data   out  WIDTH  shared channel beat = sel ? a_data : b_data
//  out_last   out  1      shared channel last flag, muxed like out_data
//  out_ready  in   1      downstream accepts beat
//  sel        out  1      registered mux select: 1 = A, 0 = B
//  grant_a    out  1      A owns channel (state OWN_A)
//  grant_b    out  1      B owns channel (state OWN_B)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, sel=0, beat_cnt=0, last_owner=B (A wins first tie);
//    grant_a=grant_b=0, a_ready=b_ready=0, out_valid=0. Reset mid-burst aborts it; no beat lost
//    silently: the requester sees ready=0 and must re-offer after reset.
//  - States: IDLE, OWN_A, OWN_B. sel/grant_* are registered from state.
//  - IDLE: out_valid=0, both ready=0. Next edge: only A valid -> OWN_A; only B -> OWN_B;
//    both -> the one != last_owner; none -> IDLE. Arbitration latency: 1 cycle.
//  - OWN_x: out_valid=x_valid, x_ready=out_ready, other ready=0 (combinational routing).
//    Transfer = x_valid & out_ready. Each transfer increments beat_cnt.
//  - Release on transfer with x_last, or transfer when beat_cnt==MAX_BEATS-1 (forced).
//    On release: last_owner<=x, beat_cnt<=0; if other valid that cycle -> OWN_other directly
//    (no idle bubble), else IDLE. Release after a forced handover when other idle -> IDLE,
//    then x may win again next arbitration (it is the only requester).
//  - Owner deasserting valid mid-burst: grant held, no timeout; out_valid follows x_valid.
//  - out_ready low: grant and beat_cnt hold; no state change.
//  - MAX_BEATS=1: every beat releases; alternation when both request continuously.
//  - No data is registered; zero-latency path from owner to out_*.
// STRUCTURE
//  - Shared package mux_arb_pkg: state encodings (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2),
//    owner encoding (OWNER_A=1'b1, OWNER_B=1'b0, matching sel).
//  - One sub-module: the existing 2:1 mux, instantiated per bit-vector for out_data/out_last
//    with sel as its select; FSM, counter and handshake routing live in this module.
// TESTING
//  1 Reset: reset=1 with a_valid=b_valid=1 -> all outputs 0, sel=0; release -> cycle+1 grant_a=1, sel=1.
//  2 Solo burst: A sends 3 beats (0x11,0x22,0x33 last), out_ready=1 -> out_data follows, IDLE after beat 3.
//  3 Tie/round-robin: both request 1-beat bursts continuously -> grants alternate A,B,A,B with no IDLE cycle.
//  4 Forced handover: MAX_BEATS=4, A sends 6-beat burst, B waiting -> A 4 beats, B burst, then A's last 2.
//  5 Backpressure: out_ready=0 for 3 cycles mid-burst -> a_ready=0, beat_cnt and out_data stable, no loss.
//  6 Async reset mid-burst after beat 2 of 4 -> outputs 0 immediately (before clock edge); restart from A.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
// State and owner constants, plus the tie-break helper.
package mux_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    // Owner encoding matches the mux select polarity
    localparam logic OWNER_A = 1'b1;
    localparam logic OWNER_B = 1'b0;

    // On a tie the requester that did not own the channel last wins
    function automatic logic tie_winner(input logic last_owner);
        return (last_owner == OWNER_B) ? OWNER_A : OWNER_B;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux2.sv
// Plain 2:1 mux, one instance per routed bit-vector.
// y = s ? d1 : d0.
module mux2_rr_arbiter_mux2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d0,
    input  logic         s,
    output logic [W-1:0] y
);

    // Select between the two inputs
    always_comb begin
        y = s ? d1 : d0;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux channel between A and B.
// Grants whole bursts, with a forced handover after MAX_BEATS beats.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             grant_a,
    output logic             grant_b
);

    localparam int CW = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS - 1);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          last_owner;
    logic          owner_nx;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_nx;

    logic own_valid;
    logic own_last;
    logic xfer;
    logic done;

    // Pick the current owner's handshake and detect burst release
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        unique case (state)
            OWN_A: begin
                own_valid = a_valid;
                own_last  = a_last;
            end
            OWN_B: begin
                own_valid = b_valid;
                own_last  = b_last;
            end
            default: ;
        endcase
        xfer = own_valid & out_ready;
        done = xfer & (own_last | (beat_cnt == CNT_MAX));
    end

    // Next-state, beat counter and round-robin pointer
    always_comb begin
        state_nx = state;
        owner_nx = last_owner;
        cnt_nx   = beat_cnt;
        unique case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_nx = (tie_winner(last_owner) == OWNER_A) ?
                               OWN_A : OWN_B;
                end else if (a_valid) begin
                    state_nx = OWN_A;
                end else if (b_valid) begin
                    state_nx = OWN_B;
                end
            end
            OWN_A: begin
                if (done) begin
                    owner_nx = OWNER_A;
                    cnt_nx   = '0;
                    state_nx = b_valid ? OWN_B : IDLE;
                end else if (xfer) begin
                    cnt_nx = beat_cnt + 1'b1;
                end
            end
            OWN_B: begin
                if (done) begin
                    owner_nx = OWNER_B;
                    cnt_nx   = '0;
                    state_nx = a_valid ? OWN_A : IDLE;
                end else if (xfer) begin
                    cnt_nx = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter and registered select/grant flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWNER_B;
            beat_cnt   <= '0;
            sel        <= 1'b0;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_owner <= owner_nx;
            beat_cnt   <= cnt_nx;
            grant_a    <= (state_nx == OWN_A);
            grant_b    <= (state_nx == OWN_B);
            if (state_nx == OWN_A) begin
                sel <= OWNER_A;
            end else if (state_nx == OWN_B) begin
                sel <= OWNER_B;
            end
        end
    end

    // Route the handshake between the owner and the shared channel
    always_comb begin
        out_valid = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        unique case (state)
            OWN_A: begin
                out_valid = a_valid;
                a_ready   = out_ready;
            end
            OWN_B: begin
                out_valid = b_valid;
                b_ready   = out_ready;
            end
            default: ;
        endcase
    end

    mux2_rr_arbiter_mux2 #(
        .W (WIDTH)
    ) u_mux_data (
        .d1 (a_data),
        .d0 (b_data),
        .s  (sel),
        .y  (out_data)
    );

    mux2_rr_arbiter_mux2 #(
        .W (1)
    ) u_mux_last (
        .d1 (a_last),
        .d0 (b_last),
        .s  (sel),
        .y  (out_last)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (WIDTH=8, MAX_BEATS=4).
// Per-cycle vector table plus hand sequences for reset cases.
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       reset;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       sel;
    logic       grant_a;
    logic       grant_b;

    int n_chk;
    int n_fail;

    mux2_rr_arbiter #(
        .WIDTH     (8),
        .MAX_BEATS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant_a   (grant_a),
        .grant_b   (grant_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       bv;
        logic [7:0] bd;
        logic       bl;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       ar;
        logic       br;
        logic       sel;
        logic       ga;
        logic       gb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic av, input logic [7:0] ad, input logic al,
        input logic bv, input logic [7:0] bd, input logic bl,
        input logic ordy,
        input logic ov, input logic [7:0] od, input logic ol,
        input logic ar, input logic br,
        input logic s, input logic ga, input logic gb);
        vec_t v;
        v.av = av; v.ad = ad; v.al = al;
        v.bv = bv; v.bd = bd; v.bl = bl;
        v.ordy = ordy;
        v.ov = ov; v.od = od; v.ol = ol;
        v.ar = ar; v.br = br;
        v.sel = s; v.ga = ga; v.gb = gb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad,
                         input logic al, input logic bv,
                         input logic [7:0] bd, input logic bl,
                         input logic ordy);
        a_valid   = av;
        a_data    = ad;
        a_last    = al;
        b_valid   = bv;
        b_data    = bd;
        b_last    = bl;
        out_ready = ordy;
    endtask

    initial begin
        // solo A burst 11,22,33
        vecs.push_back(mk(1,8'h11,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 0,0,0));
        vecs.push_back(mk(1,8'h11,0, 0,8'h00,0, 1, 1,8'h11,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h22,0, 0,8'h00,0, 1, 1,8'h22,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h33,1, 0,8'h00,0, 1, 1,8'h33,1, 1,0, 1,1,0));
        vecs.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 1,0,0));
        // tie, 1-beat bursts: B (A owned last), A, B, A
        vecs.push_back(mk(1,8'hA1,1, 1,8'hB1,1, 1, 0,8'hA1,1, 0,0, 1,0,0));
        vecs.push_back(mk(1,8'hA1,1, 1,8'hB2,1, 1, 1,8'hB2,1, 0,1, 0,0,1));
        vecs.push_back(mk(1,8'hA2,1, 1,8'hB3,1, 1, 1,8'hA2,1, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'hA3,1, 1,8'hB3,1, 1, 1,8'hB3,1, 0,1, 0,0,1));
        vecs.push_back(mk(1,8'hA3,1, 0,8'h00,0, 1, 1,8'hA3,1, 1,0, 1,1,0));
        vecs.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 1,0,0));
        // forced handover: A 6 beats, B 1-beat burst waiting
        vecs.push_back(mk(1,8'h01,0, 0,8'h00,0, 1, 0,8'h01,0, 0,0, 1,0,0));
        vecs.push_back(mk(1,8'h01,0, 1,8'hC1,1, 1, 1,8'h01,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h02,0, 1,8'hC1,1, 1, 1,8'h02,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h03,0, 1,8'hC1,1, 1, 1,8'h03,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h04,0, 1,8'hC1,1, 1, 1,8'h04,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h05,0, 1,8'hC1,1, 1, 1,8'hC1,1, 0,1, 0,0,1));
        vecs.push_back(mk(1,8'h05,0, 0,8'h00,0, 1, 1,8'h05,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'h06,1, 0,8'h00,0, 1, 1,8'h06,1, 1,0, 1,1,0));
        vecs.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 1,0,0));
        // valid gap, backpressure, forced release, A wins again
        vecs.push_back(mk(1,8'hD1,0, 0,8'h00,0, 1, 0,8'hD1,0, 0,0, 1,0,0));
        vecs.push_back(mk(1,8'hD1,0, 0,8'h00,0, 1, 1,8'hD1,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'hD2,0, 0,8'h00,0, 1, 1,8'hD2,0, 1,0, 1,1,0));
        vecs.push_back(mk(0,8'hD3,0, 0,8'h00,0, 1, 0,8'hD3,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'hD3,0, 0,8'h00,0, 0, 1,8'hD3,0, 0,0, 1,1,0));
        vecs.push_back(mk(1,8'hD3,0, 0,8'h00,0, 0, 1,8'hD3,0, 0,0, 1,1,0));
        vecs.push_back(mk(1,8'hD3,0, 0,8'h00,0, 0, 1,8'hD3,0, 0,0, 1,1,0));
        vecs.push_back(mk(1,8'hD3,0, 0,8'h00,0, 1, 1,8'hD3,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'hD4,0, 0,8'h00,0, 1, 1,8'hD4,0, 1,0, 1,1,0));
        vecs.push_back(mk(1,8'hD5,0, 0,8'h00,0, 1, 0,8'hD5,0, 0,0, 1,0,0));
        vecs.push_back(mk(1,8'hD5,1, 0,8'h00,0, 1, 1,8'hD5,1, 1,0, 1,1,0));
        vecs.push_back(mk(0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0, 0,0, 1,0,0));

        n_chk  = 0;
        n_fail = 0;

        // reset with both requesting: everything quiet, then A first
        reset = 1'b1;
        drive(1, 8'h5A, 0, 1, 8'hA5, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst.a_ready", {7'd0, a_ready}, 8'd0);
        chk("rst.b_ready", {7'd0, b_ready}, 8'd0);
        chk("rst.grant_a", {7'd0, grant_a}, 8'd0);
        chk("rst.grant_b", {7'd0, grant_b}, 8'd0);
        chk("rst.sel", {7'd0, sel}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel.grant_a", {7'd0, grant_a}, 8'd0);
        @(negedge clk);
        #1;
        chk("rel+1.grant_a", {7'd0, grant_a}, 8'd1);
        chk("rel+1.grant_b", {7'd0, grant_b}, 8'd0);
        chk("rel+1.sel", {7'd0, sel}, 8'd1);
        chk("rel+1.a_ready", {7'd0, a_ready}, 8'd1);
        chk("rel+1.out_data", out_data, 8'h5A);

        // clean restart for the table
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].ad, vecs[i].al,
                  vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d.out_valid", i), {7'd0, out_valid},
                {7'd0, vecs[i].ov});
            chk($sformatf("v%0d.out_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d.out_last", i), {7'd0, out_last},
                {7'd0, vecs[i].ol});
            chk($sformatf("v%0d.a_ready", i), {7'd0, a_ready},
                {7'd0, vecs[i].ar});
            chk($sformatf("v%0d.b_ready", i), {7'd0, b_ready},
                {7'd0, vecs[i].br});
            chk($sformatf("v%0d.sel", i), {7'd0, sel},
                {7'd0, vecs[i].sel});
            chk($sformatf("v%0d.grant_a", i), {7'd0, grant_a},
                {7'd0, vecs[i].ga});
            chk($sformatf("v%0d.grant_b", i), {7'd0, grant_b},
                {7'd0, vecs[i].gb});
        end

        // async reset after beat 2 of a 4-beat A burst
        @(negedge clk);
        drive(1, 8'hE1, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        #1;
        chk("ar.beat1.grant_a", {7'd0, grant_a}, 8'd1);
        @(negedge clk);
        drive(1, 8'hE2, 0, 0, 8'h00, 0, 1);
        @(negedge clk);
        drive(1, 8'hE3, 0, 0, 8'h00, 0, 1);
        #1;
        chk("ar.beat3.out_valid", {7'd0, out_valid}, 8'd1);
        chk("ar.beat3.out_data", out_data, 8'hE3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.now.out_valid", {7'd0, out_valid}, 8'd0);
        chk("ar.now.a_ready", {7'd0, a_ready}, 8'd0);
        chk("ar.now.grant_a", {7'd0, grant_a}, 8'd0);
        chk("ar.now.grant_b", {7'd0, grant_b}, 8'd0);
        chk("ar.now.sel", {7'd0, sel}, 8'd0);
        @(negedge clk);
        drive(1, 8'hE3, 0, 1, 8'hF1, 1, 1);
        reset = 1'b0;
        #1;
        chk("ar.rel.grant_a", {7'd0, grant_a}, 8'd0);
        @(negedge clk);
        #1;
        chk("ar.rel+1.grant_a", {7'd0, grant_a}, 8'd1);
        chk("ar.rel+1.grant_b", {7'd0, grant_b}, 8'd0);
        chk("ar.rel+1.out_data", out_data, 8'hE3);
        chk("ar.rel+1.b_ready", {7'd0, b_ready}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
